// File: rtl/beat_pkg.sv
// Shared types and constants for the beat sequencer: controller states,
// beat index width and tempo-select encodings.
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int BEAT_W = 12;

  localparam logic [1:0] TEMPO_X1 = 2'd0;
  localparam logic [1:0] TEMPO_X2 = 2'd1;
  localparam logic [1:0] TEMPO_X4 = 2'd2;
  localparam logic [1:0] TEMPO_X8 = 2'd3;

endpackage

// File: rtl/tempo_divider.sv
// Clock-to-beat divider: counts clocks while enabled and flags the last clock
// of each beat, with the beat length scaled down by tempo_sel.
module tempo_divider #(
  parameter int BASE_DIV = 25_000_000,
  parameter int DIV_W    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] tempo_sel,
  output logic       tick
);
  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] limit_m1;

  assign limit_m1 = (BASE >> tempo_sel) - DIV_W'(1);
  // >= rather than == so a tempo speed-up mid-beat cannot skip past the end.
  assign tick     = en & (div_cnt_q >= limit_m1);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/beat_sequencer_ctrl.sv
// Play/pause/stop/loop controller that steps the beat index on tempo ticks
// and gates the decoder AM flag into a play-qualified registered enable.
module beat_sequencer_ctrl
  import beat_pkg::*;
#(
  parameter int BASE_DIV = 25_000_000,
  parameter int BEAT_LEN = 64,
  parameter int DIV_W    = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic              is_am,
  output logic [BEAT_W-1:0] ibeatNum,
  output logic              beat_tick,
  output logic              am_en,
  output logic              playing,
  output logic              paused,
  output logic              song_done
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_LEN - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              am_en_q, am_en_d;
  logic              div_en, div_clr, div_tick;

  tempo_divider #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (div_en),
    .clr       (div_clr),
    .tempo_sel (tempo_sel),
    .tick      (div_tick)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    div_en  = 1'b0;
    div_clr = 1'b0;
    am_en_d = (state_q == PLAY) & is_am;
    case (state_q)
      IDLE: begin
        if (!stop && !pause && start) begin
          state_d = PLAY;
          beat_d  = '0;
          div_clr = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          beat_d  = '0;
          div_clr = 1'b1;
        end else if (pause) begin
          // Divider left disabled: count and any due tick are held.
          state_d = PAUSE;
        end else begin
          div_en = 1'b1;
          if (div_tick) begin
            tick_d = 1'b1;
            if (beat_q < LAST_BEAT) begin
              beat_d = beat_q + BEAT_W'(1);
            end else begin
              beat_d = '0;
              if (!loop_en) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          beat_d  = '0;
          div_clr = 1'b1;
        end else if (!pause && start) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        div_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      am_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      am_en_q <= am_en_d;
    end
  end

  assign ibeatNum  = beat_q;
  assign beat_tick = tick_q;
  assign song_done = done_q;
  assign am_en     = am_en_q;
  assign playing   = (state_q == PLAY);
  assign paused    = (state_q == PAUSE);

endmodule

// File: tb/tb_beat_sequencer_ctrl.sv
// Directed bench for beat_sequencer_ctrl (BASE_DIV=8, BEAT_LEN=4): expected
// beat ticks are queued by the stimulus and checked by a separate monitor.
module tb_beat_sequencer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [1:0]  tempo_sel = 2'd0;
  logic        is_am;
  logic [11:0] ibeatNum;
  logic        beat_tick, am_en, playing, paused, song_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] beat;
    logic        done;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign is_am = (ibeatNum == 12'd1);

  beat_sequencer_ctrl #(
    .BASE_DIV (8),
    .BEAT_LEN (4),
    .DIV_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .tempo_sel (tempo_sel),
    .is_am     (is_am),
    .ibeatNum  (ibeatNum),
    .beat_tick (beat_tick),
    .am_en     (am_en),
    .playing   (playing),
    .paused    (paused),
    .song_done (song_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0d (t=%0t)", name, act, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic push(input logic [11:0] b, input logic d);
    exp_t e;
    e.beat = b;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every beat_tick pops one expected beat and compares.
  initial begin
    forever begin
      @(negedge clk);
      if (beat_tick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 32'(ibeatNum), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tick_beat", 32'(ibeatNum), 32'(e.beat));
          check("tick_song_done", 32'(song_done), 32'(e.done));
        end
      end else if (song_done) begin
        check("song_done_without_tick", 32'(song_done), 32'd0);
      end
    end
  end

  initial begin
    // Async reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_ibeat", 32'(ibeatNum), 0);
    check("rst_outputs", {27'd0, beat_tick, am_en, playing, paused, song_done}, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("idle_playing", 32'(playing), 0);

    // Song at tempo x1: ticks every 8 clocks, ends with song_done
    push(12'd1, 1'b0); push(12'd2, 1'b0); push(12'd3, 1'b0); push(12'd0, 1'b1);
    pulse_start();
    check("play_after_start", 32'(playing), 1);
    step(7);
    check("beat0_before_tick", 32'(ibeatNum), 0);
    step(1);
    check("beat1", 32'(ibeatNum), 1);
    check("am_lag", 32'(am_en), 0);
    step(1);
    check("am_rise", 32'(am_en), 1);
    step(7);
    check("beat2", 32'(ibeatNum), 2);
    check("am_hold", 32'(am_en), 1);
    step(1);
    check("am_fall", 32'(am_en), 0);
    step(15);
    check("song_end_playing", 32'(playing), 0);
    check("song_end_beat", 32'(ibeatNum), 0);
    step(10);
    check("idle_stays", 32'(playing), 0);

    // Loop at tempo x8: tick every clock, beat wraps, no song_done
    loop_en = 1'b1;
    tempo_sel = 2'd3;
    for (int i = 0; i < 10; i++) push(12'((i + 1) % 4), 1'b0);
    pulse_start();
    step(10);
    check("loop_playing", 32'(playing), 1);
    check("loop_beat", 32'(ibeatNum), 2);

    // All three commands together: stop wins
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    step(1);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    check("multi_state", {30'd0, playing, paused}, 0);
    check("multi_beat", 32'(ibeatNum), 0);
    check("multi_tick", 32'(beat_tick), 0);
    loop_en = 1'b0;
    tempo_sel = 2'd0;
    step(3);

    // Pause at div_cnt=5 on beat 2, then resume
    push(12'd1, 1'b0); push(12'd2, 1'b0);
    pulse_start();
    step(21);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("paused_flag", {30'd0, playing, paused}, 1);
    step(20);
    check("pause_hold_beat", 32'(ibeatNum), 2);
    check("pause_hold_flag", 32'(paused), 1);
    push(12'd3, 1'b0);
    pulse_start();
    check("resume_playing", 32'(playing), 1);
    step(2);
    check("resume_no_early_tick", 32'(ibeatNum), 2);
    step(1);
    check("resume_tick", 32'(beat_tick), 1);
    check("resume_beat", 32'(ibeatNum), 3);

    // Tempo x1 -> x4 at div_cnt=6: beat ends on next clock
    step(6);
    tempo_sel = 2'd2;
    push(12'd0, 1'b1);
    step(1);
    check("tempo_tick", 32'(beat_tick), 1);
    check("tempo_end_playing", 32'(playing), 0);
    tempo_sel = 2'd0;
    step(2);

    // am_en drops one clock after pause
    push(12'd1, 1'b0);
    pulse_start();
    step(9);
    check("am_on_beat1", 32'(am_en), 1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("am_pause_edge", 32'(am_en), 1);
    step(1);
    check("am_pause_off", 32'(am_en), 0);

    // Reset mid-beat
    pulse_start();
    step(3);
    check("pre_reset_playing", 32'(playing), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {27'd0, beat_tick, am_en, playing, paused, song_done}, 0);
    check("mid_rst_beat", 32'(ibeatNum), 0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("post_rst_idle", {30'd0, playing, paused}, 0);
    check("post_rst_beat", 32'(ibeatNum), 0);

    check("pending_ticks", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
